// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the K=3, rate-1/2 Viterbi frame sequencer.
// Trellis convention: next = {u, cur[1]}, so the predecessor of s is {s[0], d[s]}.
package viterbi_pkg;

  typedef enum logic [2:0] {
    CLR,
    ACQ,
    DRAIN,
    TB,
    OUT
  } state_t;

  localparam int NUM_STATES = 4;
  localparam int SW = $clog2(NUM_STATES);

  function automatic logic [SW-1:0] tb_prev(input logic [SW-1:0] s,
                                            input logic [NUM_STATES-1:0] d);
    return {s[0], d[s]};
  endfunction

endpackage

// File: rtl/viterbi_ctrl.sv
// Frame sequencer: acquires FRAME_LEN symbol pairs, drives ACS and survivor writes,
// traces back from the best end state, then streams the decoded bits in time order.
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int AW        = $clog2(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  input  logic                  cx0,
  input  logic                  cx1,
  output logic                  cx0_q,
  output logic                  cx1_q,
  output logic                  pm_clear,
  output logic                  acs_en,
  output logic                  sm_we,
  output logic [AW-1:0]         sm_addr,
  input  logic [NUM_STATES-1:0] sm_rdata,
  input  logic [SW-1:0]         best_state,
  output logic                  bit_valid,
  input  logic                  bit_ready,
  output logic                  bit_out,
  output logic                  bit_last,
  output logic                  busy
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [SW-1:0]        tb_state_reg;
  logic [FRAME_LEN-1:0] buf_reg;

  logic [SW-1:0]        tb_cur;
  logic [SW-1:0]        tb_next;
  logic [AW-1:0]        out_idx_next;
  logic                 cnt_last;

  // The first traceback step starts from the datapath's best end state.
  always_comb begin
    tb_cur       = (cnt_reg == '0) ? best_state : tb_state_reg;
    tb_next      = tb_prev(tb_cur, sm_rdata);
    out_idx_next = cnt_reg[AW-1:0] + AW'(1);
    cnt_last     = (cnt_reg == LAST);
  end

  // During traceback sm_addr equals FRAME_LEN-1-j, which is also the bit's slot.
  always_ff @(posedge clk) begin
    if (state_reg == TB) begin
      buf_reg[sm_addr] <= tb_cur[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLR;
      cnt_reg      <= '0;
      tb_state_reg <= '0;
      sym_ready    <= 1'b0;
      cx0_q        <= 1'b0;
      cx1_q        <= 1'b0;
      pm_clear     <= 1'b1;
      acs_en       <= 1'b0;
      sm_we        <= 1'b0;
      sm_addr      <= '0;
      bit_valid    <= 1'b0;
      bit_out      <= 1'b0;
      bit_last     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      pm_clear <= 1'b0;
      acs_en   <= 1'b0;
      sm_we    <= 1'b0;
      unique case (state_reg)
        CLR: begin
          state_reg <= ACQ;
          cnt_reg   <= '0;
          sym_ready <= 1'b1;
          busy      <= 1'b0;
        end
        ACQ: begin
          if (sym_valid && sym_ready) begin
            cx0_q   <= cx0;
            cx1_q   <= cx1;
            acs_en  <= 1'b1;
            sm_we   <= 1'b1;
            sm_addr <= cnt_reg[AW-1:0];
            busy    <= 1'b1;
            if (cnt_last) begin
              state_reg <= DRAIN;
              sym_ready <= 1'b0;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        DRAIN: begin
          state_reg <= TB;
          sm_addr   <= LAST[AW-1:0];
        end
        TB: begin
          tb_state_reg <= tb_next;
          if (cnt_last) begin
            // buf_reg[0] is written on this same edge, so forward it directly.
            state_reg <= OUT;
            cnt_reg   <= '0;
            sm_addr   <= '0;
            bit_valid <= 1'b1;
            bit_out   <= tb_cur[1];
            bit_last  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
            sm_addr <= sm_addr - AW'(1);
          end
        end
        OUT: begin
          if (bit_ready) begin
            if (cnt_last) begin
              state_reg <= CLR;
              cnt_reg   <= '0;
              pm_clear  <= 1'b1;
              bit_valid <= 1'b0;
              bit_last  <= 1'b0;
            end else begin
              cnt_reg  <= cnt_reg + CW'(1);
              bit_out  <= buf_reg[out_idx_next];
              bit_last <= ((cnt_reg + CW'(1)) == LAST);
            end
          end
        end
        default: begin
          state_reg <= CLR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl with a behavioural BMU/ACS/survivor model and a bit scoreboard.
module tb_viterbi_ctrl;

  localparam int FL = 8;
  localparam int AW = 3;
  localparam int PM_MAX = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          sym_valid;
  logic          sym_ready;
  logic          cx0, cx1;
  logic          cx0_q, cx1_q;
  logic          pm_clear, acs_en, sm_we;
  logic [AW-1:0] sm_addr;
  logic [3:0]    sm_rdata;
  logic [1:0]    best_state;
  logic          bit_valid, bit_ready, bit_out, bit_last, busy;

  always #5 clk = ~clk;

  viterbi_ctrl #(.FRAME_LEN(FL), .AW(AW)) dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .cx0(cx0), .cx1(cx1), .cx0_q(cx0_q), .cx1_q(cx1_q),
    .pm_clear(pm_clear), .acs_en(acs_en), .sm_we(sm_we), .sm_addr(sm_addr),
    .sm_rdata(sm_rdata), .best_state(best_state),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_out(bit_out),
    .bit_last(bit_last), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural datapath: BMU, ACS, survivor memory ----------------
  int         pm [4];
  int         nm [4];
  logic [3:0] dec;
  logic [3:0] mem [FL];
  logic [1:0] ss, pa, pb;
  int         ma, mb, bm;

  function automatic int branch(input int pmv, input logic [1:0] p, input logic u,
                                input logic c0r, input logic c1r);
    logic c0, c1;
    c0 = u ^ p[1] ^ p[0];
    c1 = u ^ p[0];
    return pmv + int'(c0 ^ c0r) + int'(c1 ^ c1r);
  endfunction

  always_comb begin
    ss = 2'd0; pa = 2'd0; pb = 2'd0; ma = 0; mb = 0; dec = 4'd0;
    for (int s = 0; s < 4; s++) nm[s] = 0;
    for (int s = 0; s < 4; s++) begin
      ss = 2'(s);
      pa = {ss[0], 1'b0};
      pb = {ss[0], 1'b1};
      ma = branch(pm[pa], pa, ss[1], cx0_q, cx1_q);
      mb = branch(pm[pb], pb, ss[1], cx0_q, cx1_q);
      if (mb < ma) begin
        nm[s]  = mb;
        dec[s] = 1'b1;
      end else begin
        nm[s]  = ma;
        dec[s] = 1'b0;
      end
    end
  end

  always_comb begin
    best_state = 2'd0;
    bm = pm[0];
    for (int s = 1; s < 4; s++) begin
      if (pm[s] < bm) begin
        bm = pm[s];
        best_state = 2'(s);
      end
    end
  end

  assign sm_rdata = mem[sm_addr];

  always @(posedge clk) begin
    if (pm_clear) begin
      pm[0] <= 0;
      for (int s = 1; s < 4; s++) pm[s] <= PM_MAX;
    end else if (acs_en) begin
      for (int s = 0; s < 4; s++) pm[s] <= nm[s];
    end
    if (sm_we) mem[sm_addr] <= dec;
  end

  // ---------------- scoreboard and monitors ----------------
  typedef struct packed {
    logic b;
    logic last;
  } exp_t;
  exp_t exp_q[$];

  logic exp_acs  = 1'b0;
  int   exp_addr = 0;
  int   hs_idx   = 0;

  // One cycle after every accepted symbol: acs_en, sm_we and the symbol's address.
  always @(negedge clk) begin
    chk("acs_en", acs_en, exp_acs);
    chk("sm_we", sm_we, exp_acs);
    if (exp_acs) chk("sm_addr_wr", sm_addr, exp_addr);
    exp_acs = sym_valid && sym_ready && !reset;
    if (pm_clear || reset) hs_idx = 0;
    if (exp_acs) begin
      exp_addr = hs_idx;
      hs_idx   = (hs_idx + 1) % FL;
    end
  end

  logic stall_prev = 1'b0;
  logic prev_out   = 1'b0;
  logic prev_last  = 1'b0;
  logic clr_due    = 1'b0;
  exp_t e_pop;

  always @(negedge clk) begin
    if (stall_prev) begin
      chk("stall_valid", bit_valid, 1);
      chk("stall_out", bit_out, prev_out);
      chk("stall_last", bit_last, prev_last);
    end
    if (clr_due) begin
      chk("next_pm_clear", pm_clear, 1);
      chk("next_valid_low", bit_valid, 0);
      clr_due = 1'b0;
    end
    if (bit_valid && bit_ready && !reset) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        e_pop = exp_q.pop_front();
        chk("bit_out", bit_out, e_pop.b);
        chk("bit_last", bit_last, e_pop.last);
      end
      clr_due = bit_last;
    end
    stall_prev = bit_valid && !bit_ready && !reset;
    prev_out   = bit_out;
    prev_last  = bit_last;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [FL-1:0] bits);
    exp_t e;
    for (int n = 0; n < FL; n++) begin
      e.b    = bits[FL-1-n];
      e.last = (n == FL - 1);
      exp_q.push_back(e);
    end
  endtask

  // Pairs written as {cx0,cx1}, first pair in the top bits. Returns with the DUT in DRAIN.
  task automatic send_frame(input logic [2*FL-1:0] syms, input bit gaps, output int hs_cyc);
    logic [1:0] p;
    int w;
    hs_cyc = 0;
    for (int n = 0; n < FL; n++) begin
      p = syms[2*FL-1-2*n -: 2];
      sym_valid = 1'b1;
      cx0 = p[1];
      cx1 = p[0];
      w = 0;
      @(negedge clk);
      while (!sym_ready && w < 50) begin
        w++;
        @(negedge clk);
      end
      if (w >= 50) begin
        chk("sym_ready_timeout", 0, 1);
        sym_valid = 1'b0;
        return;
      end
      hs_cyc = cyc;
      tick();
      if (gaps && n != FL - 1) begin
        sym_valid = 1'b0;
        tick();
      end
    end
    sym_valid = 1'b0;
  endtask

  // Traceback address walk and first-bit latency relative to the last handshake cycle.
  task automatic check_tb_phase(input int hs_cyc);
    @(negedge clk);
    chk("drain_valid_low", bit_valid, 0);
    for (int j = 0; j < FL; j++) begin
      @(negedge clk);
      chk("tb_sm_addr", sm_addr, FL - 1 - j);
      chk("tb_valid_low", bit_valid, 0);
      chk("tb_busy", busy, 1);
    end
    @(negedge clk);
    chk("first_bit_latency", cyc - hs_cyc, 10);
    chk("first_bit_valid", bit_valid, 1);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) chk("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  localparam logic [2*FL-1:0] F_ZERO = '0;
  localparam logic [2*FL-1:0] F_ENC  = 16'b11_10_00_01_01_11_00_00;
  localparam logic [2*FL-1:0] F_ERR  = 16'b11_10_10_01_01_11_00_00;
  localparam logic [FL-1:0]   B_ZERO = 8'b0000_0000;
  localparam logic [FL-1:0]   B_ENC  = 8'b1011_0000;

  int hs;
  int clr_pulses;
  int valid_seen;

  initial begin
    reset = 1'b1;
    sym_valid = 1'b0;
    cx0 = 1'b0;
    cx1 = 1'b0;
    bit_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pm_clear", pm_clear, 1);
    chk("rst_sym_ready", sym_ready, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_last", bit_last, 0);
    tick();
    reset = 1'b0;

    // Idle after reset: one clear pulse, then ready with no output.
    clr_pulses = 0;
    valid_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pm_clear) clr_pulses++;
      if (bit_valid) valid_seen++;
    end
    chk("idle_clear_pulses", clr_pulses, 1);
    chk("idle_valid_seen", valid_seen, 0);
    chk("idle_sym_ready", sym_ready, 1);
    chk("idle_busy", busy, 0);
    tick();

    // All-zero frame.
    push_bits(B_ZERO);
    send_frame(F_ZERO, 1'b0, hs);
    check_tb_phase(hs);
    wait_drain();

    // Encoded frame.
    push_bits(B_ENC);
    send_frame(F_ENC, 1'b0, hs);
    check_tb_phase(hs);
    wait_drain();

    // Single channel error on the third pair.
    push_bits(B_ENC);
    send_frame(F_ERR, 1'b0, hs);
    check_tb_phase(hs);
    wait_drain();

    // Input gaps and output back-pressure.
    push_bits(B_ENC);
    send_frame(F_ENC, 1'b1, hs);
    check_tb_phase(hs);
    tick();
    tick();
    bit_ready = 1'b0;
    repeat (3) tick();
    bit_ready = 1'b1;
    wait_drain();

    // Reset during traceback.
    send_frame(F_ENC, 1'b0, hs);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tb_pm_clear", pm_clear, 1);
    chk("rst_tb_valid", bit_valid, 0);
    chk("rst_tb_ready", sym_ready, 0);
    tick();

    // Reset during output, with the sink stalled so no bit is consumed.
    bit_ready = 1'b0;
    send_frame(F_ERR, 1'b0, hs);
    check_tb_phase(hs);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_pm_clear", pm_clear, 1);
    chk("rst_out_valid", bit_valid, 0);
    chk("rst_out_ready", sym_ready, 0);
    bit_ready = 1'b1;
    tick();

    // Recovery frame after the aborted ones.
    push_bits(B_ENC);
    send_frame(F_ERR, 1'b0, hs);
    check_tb_phase(hs);
    wait_drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/viterbi_ctrl.md
Name: viterbi_ctrl

Overview:
Frame sequencer for the rate-1/2, K=3 (4-state) Viterbi decoder.
- Accepts received symbol pairs (cx0, cx1) over a valid/ready handshake and forwards them to the branch-metric unit.
- Drives the ACS/path-metric clear and enable and the survivor-memory write.
- Performs traceback from the best end state using survivor decisions, then streams decoded bits out in time order.
- Sits between the demodulator front end and the BMU/ACS/survivor-memory datapath.

Parameters:
- FRAME_LEN, 16, symbol pairs per frame; also decoded bits per frame; minimum 2.
- AW, $clog2(FRAME_LEN), survivor-memory address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- sym_valid  in  1  symbol pair present.
- sym_ready  out  1  controller accepts a symbol pair.
- cx0  in  1  received code bit 0.
- cx1  in  1  received code bit 1.
- cx0_q  out  1  registered cx0 to BMU.
- cx1_q  out  1  registered cx1 to BMU.
- pm_clear  out  1  clear path metrics (state 00 = 0, others = max).
- acs_en  out  1  ACS/path-metric registers update this cycle.
- sm_we  out  1  survivor-memory write enable.
- sm_addr  out  AW  survivor-memory address, write and read.
- sm_rdata  in  4  decision bits for states 3..0 at sm_addr; combinational read.
- best_state  in  2  minimum-metric state from the datapath.
- bit_valid  out  1  decoded bit valid.
- bit_ready  in  1  sink accepts the decoded bit.
- bit_out  out  1  decoded bit.
- bit_last  out  1  last bit of the frame.
- busy  out  1  high in every state except ACQ before the first handshake of a frame.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- On reset:
  - state = CLR.
  - All outputs 0, except pm_clear = 1 in CLR.
  - Counters = 0 and tb_state = 0.
  - Reset mid-frame abandons the frame; bit buffer contents are don't-care.
- Trellis convention: next = {u, cur[1]}.
  - Predecessor of state s = {s[0], sm_rdata[s]}.
  - The decoded bit for the stage ending in s is s[1].
- State machine:
  - CLR: pm_clear = 1 for exactly one cycle, then ACQ.
  - ACQ: sym_ready = 1.
    - On a handshake, latch cx0/cx1 into cx0_q/cx1_q and increment the symbol count k.
    - The cycle after each handshake: acs_en = 1, sm_we = 1, sm_addr = index of that symbol (0..FRAME_LEN-1).
    - Throughput is 1 symbol per cycle. Gaps in sym_valid produce gaps in acs_en; cx*_q holds.
    - After the FRAME_LEN-th handshake, go to DRAIN, with sym_ready = 0 from the next cycle.
  - DRAIN: one cycle carrying the final acs_en/sm_we, then TB.
  - TB: FRAME_LEN cycles, j = 0..FRAME_LEN-1.
    - j = 0: tb_state is loaded from best_state; sm_addr = FRAME_LEN-1.
    - Every cycle: buf[FRAME_LEN-1-j] = cur[1], and tb_state <= {cur[0], sm_rdata[cur]}, where cur = best_state at j = 0, else tb_state.
    - sm_addr = FRAME_LEN-1-j; sm_we = 0, acs_en = 0.
    - Go to OUT after j = FRAME_LEN-1.
  - OUT: bit_valid = 1 and bit_out = buf[i] for i = 0..FRAME_LEN-1.
    - i advances only on bit_valid && bit_ready.
    - bit_out and bit_last stay stable while stalled.
    - bit_last = 1 when i = FRAME_LEN-1.
    - The handshake on the last bit goes to CLR, so the next frame starts automatically.
- Latency: the first decoded bit is valid 2 + FRAME_LEN cycles after the last symbol handshake (DRAIN, TB, then OUT). The frame clear costs 1 cycle.
- Counters are AW+1 bits wide as needed and never wrap within a frame. Terminal counts compare against FRAME_LEN-1.
- sym_valid while not in ACQ is ignored; no back-pressure beyond sym_ready = 0.
- In ACQ, sym_valid && !sym_ready cannot occur.

Decomposition:
- Package viterbi_pkg:
  - state enum {CLR, ACQ, DRAIN, TB, OUT}.
  - Trellis constant NUM_STATES = 4.
  - Function tb_prev(state, decisions) returning {s[0], d[s]}.
- No sub-module. The bit buffer and counters stay inline.

Test Plan:
- Bench setup: the bench includes a behavioural BMU/ACS/survivor model, FRAME_LEN = 8.
- Reset, then idle: exactly one pm_clear pulse, then sym_ready = 1 and bit_valid = 0 indefinitely with no sym_valid.
- All-zero frame: 8 pairs of 00 back to back.
  - acs_en high for 8 consecutive cycles, one cycle after each handshake; sm_addr 0..7.
  - Output bits 0×8 with bit_last on the 8th.
- Encoded frame:
  - Send 11,10,00,01,01,11,00,00.
  - Expect bits 1,0,1,1,0,0,0,0 in order.
  - TB sm_addr sequence 7..0; first bit_valid 10 cycles after the last handshake.
- Single-error frame: same as the encoded frame with the 3rd pair flipped to 10 -> identical decoded bits 1,0,1,1,0,0,0,0.
- Back-pressure and gaps:
  - sym_valid toggling 1/0 -> acs_en pulses only after handshakes.
  - bit_ready low for 3 cycles mid-OUT -> bit_out/bit_last stable, no bit lost or duplicated.
  - Next frame begins with pm_clear right after the last accepted bit.
- Reset mid-TB and mid-OUT: next cycle CLR, bit_valid = 0, sym_ready = 0; a following frame decodes correctly.
